disp_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an N-digit common-anode seven-segment display. One 4-bit hex-to-seven-segment decoder is shared across all digits.
- Holds a double-buffered display word. Cycles the digit anodes at a programmable slot rate, with an anti-ghosting blank interval at the start of each slot.
- Sits between the datapath that produces values (ADC samples, equaliser gains) and the board display pins.

---
 rtl/disp_pkg.sv | 27 ++
 rtl/hex7seg_dec.sv | 12 +
 rtl/disp_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment scan controller: glyph codes, scan states, width helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs indexed by hex value, bit0 = segment a.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Zero latency; no flow control.
module hex7seg_dec
    import disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = SEG_HEX[i_nib];

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with double-buffered value and blank interval per slot.
// Pins registered one cycle after state/index; enable=0 freezes the scan and darkens the display.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 500
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an_n,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int CNT_W = clog2(PRESCALE);
    localparam int IDX_W = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N_DIGITS - 1);

    scan_state_t             r_state;
    scan_state_t             w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;

    logic [4*N_DIGITS-1:0]   r_shadow_val;
    logic [N_DIGITS-1:0]     r_shadow_dp;
    logic [4*N_DIGITS-1:0]   r_pend_val;
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic                    r_pending;

    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic [N_DIGITS-1:0]     r_an_n;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_boundary;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg_dec;
    logic                    w_dp_bit;
    logic [N_DIGITS-1:0]     w_upper_zero;
    logic [N_DIGITS-1:0]     w_an_sel;
    logic                    w_lz_blank;
    logic                    w_acc_zero;

    assign w_slot_end = enable && (r_cnt == CNT_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (enable) begin
            unique case (r_state)
                ST_BLANK: if (r_cnt == CNT_BLANK_END) w_state_nxt = ST_SHOW;
                ST_SHOW:  if (r_cnt == CNT_LAST)      w_state_nxt = ST_BLANK;
                default:  w_state_nxt = ST_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (enable) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A load on the boundary bypasses pend so no frame ever mixes old and new nibbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pending    <= 1'b0;
        end else if (load && w_boundary) begin
            r_shadow_val <= value;
            r_shadow_dp  <= dp_in;
            r_pending    <= 1'b0;
        end else if (load) begin
            r_pend_val   <= value;
            r_pend_dp    <= dp_in;
            r_pending    <= 1'b1;
        end else if (w_boundary && r_pending) begin
            r_shadow_val <= r_pend_val;
            r_shadow_dp  <= r_pend_dp;
            r_pending    <= 1'b0;
        end
    end

    always_comb begin
        w_nibble   = r_shadow_val[{r_idx, 2'b00} +: 4];
        w_dp_bit   = r_shadow_dp[r_idx];
        w_acc_zero = 1'b1;
        w_upper_zero = '0;
        w_an_sel     = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            w_acc_zero      = w_acc_zero && (r_shadow_val[4*i +: 4] == 4'h0);
            w_upper_zero[i] = w_acc_zero;
            w_an_sel[i]     = (r_idx == IDX_W'(i));
        end
        w_lz_blank = blank_lz && (r_idx != '0) && w_upper_zero[r_idx];
    end

    hex7seg_dec u_dec (
        .i_nib   (w_nibble),
        .o_seg_n (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_n      <= SEG_BLANK;
            r_dp_n       <= 1'b1;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            if (enable && (r_state == ST_SHOW)) begin
                r_an_n  <= ~w_an_sel;
                r_seg_n <= w_lz_blank ? SEG_BLANK : w_seg_dec;
                r_dp_n  <= ~w_dp_bit;
            end else begin
                r_an_n  <= '1;
                r_seg_n <= SEG_BLANK;
                r_dp_n  <= 1'b1;
            end
        end
    end

    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign an_n       = r_an_n;
    assign frame_tick = r_frame_tick;
    assign pending    = r_pending;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

    localparam int N     = 4;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = N * P;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [3:0]    an_n;
    logic          frame_tick;
    logic          pending;

    disp_scan_ctrl #(
        .N_DIGITS  (N),
        .PRESCALE  (P),
        .BLANK_CYC (B)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position within the frame plus the two value buffers.
    logic [6:0]  glyph [16];
    int          pos;
    logic [15:0] m_shadow, m_pend;
    logic [3:0]  m_sdp, m_pdp;
    logic        m_pending;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_an;
    logic        e_ft;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (model pos %0d)", tag, obs, exp, pos);
        end
    endtask

    task automatic model_edge();
        int          d, off;
        logic        bnd, lz;
        logic [3:0]  one;
        one = 4'b0001;
        if (reset) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
            pos = 0; m_pending = 1'b0;
            m_shadow = '0; m_sdp = '0; m_pend = '0; m_pdp = '0;
        end else begin
            d   = pos / P;
            off = pos % P;
            if (enable && off >= B) begin
                lz    = blank_lz && (d != 0) && ((m_shadow >> (4*d)) == 16'd0);
                e_seg = lz ? 7'h7F : glyph[m_shadow[4*d +: 4]];
                e_dp  = ~m_sdp[d];
                e_an  = ~(one << d);
            end else begin
                e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
            end
            bnd  = enable && (pos == FRAME - 1);
            e_ft = bnd;
            if (load && bnd) begin
                m_shadow = value; m_sdp = dp_in; m_pending = 1'b0;
            end else if (load) begin
                m_pend = value; m_pdp = dp_in; m_pending = 1'b1;
            end else if (bnd && m_pending) begin
                m_shadow = m_pend; m_sdp = m_pdp; m_pending = 1'b0;
            end
            if (enable) pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("seg_n", 32'(seg_n), 32'(e_seg));
        chk("dp_n", 32'(dp_n), 32'(e_dp));
        chk("an_n", 32'(an_n), 32'(e_an));
        chk("frame_tick", 32'(frame_tick), 32'(e_ft));
        chk("pending", 32'(pending), 32'(m_pending));
        chk("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) tick();
    endtask

    task automatic run_to_pos(input int target);
        int guard;
        guard = 0;
        while (pos != target && guard < 4 * FRAME) begin
            tick();
            guard++;
        end
        chk("reach_pos", 32'(pos), 32'(target));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        value = v; dp_in = dp; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        pos = 0; m_pending = 1'b0;
        m_shadow = '0; m_sdp = '0; m_pend = '0; m_pdp = '0;
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        value = '0; dp_in = '0; blank_lz = 1'b0;

        run(3);
        reset = 1'b0;
        enable = 1'b1;

        // Basic scan of 12AF with dp on digit 2.
        do_load(16'h12AF, 4'b0100);
        run(2 * FRAME);

        // Leading-zero suppression, including a blanked digit whose dp is lit.
        blank_lz = 1'b1;
        do_load(16'h0005, 4'b0100);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0000);
        run(2 * FRAME);
        blank_lz = 1'b0;

        // Last load before the boundary wins.
        run_to_pos(5);
        do_load(16'hAAAA, 4'b0000);
        run(6);
        do_load(16'hBBBB, 4'b0000);
        run(2 * FRAME);

        // Load coincident with the boundary discards an older pend.
        run_to_pos(10);
        do_load(16'h1111, 4'b1111);
        run_to_pos(FRAME - 1);
        do_load(16'h5A3C, 4'b0001);
        run(FRAME + 4);

        // Enable dropped mid-SHOW on digit 1.
        run_to_pos(P + 5);
        enable = 1'b0;
        run(10);
        do_load(16'h9876, 4'b0010);
        enable = 1'b1;
        run(2 * FRAME);

        // Reset mid-scan with a load pending.
        run_to_pos(2 * P + 3);
        do_load(16'h7777, 4'b1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(FRAME + 4);

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v = v & 16'h000F;
                1: v = v & 16'h00FF;
                2: v = v & 16'h0F0F;
                default: ;
            endcase
            value    = v;
            dp_in    = 4'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            enable   = ($urandom_range(0, 15) != 0);
            reset    = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            tick();
        end
        load = 1'b0; reset = 1'b0; enable = 1'b1;
        run(FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
